// File: rtl/sram16_bridge.sv
// sram16_bridge: runs a lane-aligned 32-bit CPU access on a 16-bit async SRAM
// as one or two half-word cycles, stalling the core through hlt until done.
module sram16_bridge #(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic              rd,
  input  logic [3:0]        wren,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              hlt,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n
);
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  localparam int PW = $clog2(WAIT_CYCLES + 2);
  localparam logic [PW-1:0] LAST = PW'(WAIT_CYCLES + 1);
  localparam logic [PW-1:0] WEND = PW'(WAIT_CYCLES);
  state_t              r_state, w_next;
  logic [PW-1:0]       r_p;
  logic [ADDR_W-2:0]   r_addr;
  logic [3:0]          r_wren;
  logic [31:0]         r_wdata, r_rdata;
  logic                r_wr;
  logic                w_req, w_act, w_hi, w_last;
  logic [1:0]          w_lane;
  logic                w_unused;
  assign w_req    = rd | (|wren);
  assign w_act    = (r_state == LO) || (r_state == HI);
  assign w_hi     = r_state == HI;
  assign w_last   = r_p == LAST;
  assign w_lane   = w_hi ? r_wren[3:2] : r_wren[1:0];
  assign rdata    = r_rdata;
  assign w_unused = ^{addr[31:ADDR_W+1], addr[1:0]};
  always_ff @(posedge CLK) begin
    if (RES) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = !w_req ? IDLE : ((|wren) && wren[1:0] == 2'b00) ? HI : LO;
      LO:      w_next = !w_last ? LO : (!r_wr || (|r_wren[3:2])) ? HI : DONE;
      HI:      w_next = w_last ? DONE : HI;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RES) begin
      r_p     <= '0;
      r_addr  <= '0;
      r_wren  <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_p <= (w_act && !w_last) ? r_p + 1'b1 : '0;
      if (r_state == IDLE && w_req) begin
        r_addr  <= addr[ADDR_W:2];
        r_wren  <= wren;
        r_wdata <= wdata;
        r_wr    <= |wren;
      end
      // each half of the read word is captured on the edge ending its strobe
      if (w_act && !r_wr && w_last) begin
        if (w_hi) r_rdata[31:16] <= sram_dq_i;
        else      r_rdata[15:0]  <= sram_dq_i;
      end
    end
  end
  always_comb begin
    hlt        = !RES && ((r_state == IDLE && w_req) || w_act);
    sram_ce_n  = !w_act;
    sram_addr  = w_act ? {r_addr, w_hi} : '0;
    sram_dq_oe = w_act && r_wr;
    sram_dq_o  = sram_dq_oe ? (w_hi ? r_wdata[31:16] : r_wdata[15:0]) : '0;
    sram_we_n  = !(sram_dq_oe && r_p != '0 && r_p <= WEND);
    sram_oe_n  = !(w_act && !r_wr && r_p != '0);
    sram_lb_n  = !w_act || (r_wr && !w_lane[0]);
    sram_ub_n  = !w_act || (r_wr && !w_lane[1]);
  end
endmodule
